// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: sequences the serial frame receiver.
// Arms the receiver, collects its bytes into a 16-byte staging buffer, and
// judges each completed frame. Frames are judged on the receiver's noise, CRC
// and framing flags, then on length. Good frames drain to the host as a byte
// stream; bad frames are dropped and counted.
//
// Host stream handshake: out_valid/out_data/out_last are held stable until a
// cycle where out_valid & out_ready are both high. That cycle transfers the
// byte. out_valid never falls without a transfer, except on reset.

module rx_frame_ctrl #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int BUF_DEPTH      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] cfg_baudrate,
    output logic [7:0] rx_baudrate,
    output logic       rx_arm,
    input  logic       rx_byte_valid,
    input  logic [7:0] rx_byte,
    input  logic [3:0] rx_framesize,
    input  logic       rx_frame_done,
    input  logic       rx_nf,
    input  logic       rx_crce,
    input  logic       rx_fe,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic [2:0] err_code,
    output logic [7:0] good_count,
    output logic [7:0] err_count,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HUNT  = 3'd1;
    localparam logic [2:0] ST_RECV  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DROP  = 3'd5;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_NOISE   = 3'd1;
    localparam logic [2:0] ERR_CRC     = 3'd2;
    localparam logic [2:0] ERR_FRAMING = 3'd3;
    localparam logic [2:0] ERR_LENGTH  = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;

    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

    logic [2:0]  state_q,    state_d;
    logic [3:0]  wptr_q,     wptr_d;
    logic [3:0]  rptr_q,     rptr_d;
    logic [3:0]  len_q,      len_d;
    logic [15:0] tmo_q,      tmo_d;
    logic        ovf_q,      ovf_d;
    logic        nf_q,       nf_d;
    logic        crce_q,     crce_d;
    logic        fe_q,       fe_d;
    logic [2:0]  pend_err_q, pend_err_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [7:0]  good_q,     good_d;
    logic [7:0]  errc_q,     errc_d;
    logic [7:0]  baud_q,     baud_d;

    logic [7:0]  buf_q [BUF_DEPTH];
    logic        buf_we;

    logic [16:0] tmo_inc;
    logic [2:0]  judge_err;
    logic        len_bad;
    logic        last_rd;

    // The expected length: a zero length field means a one-byte frame.
    function automatic logic [3:0] frame_len(input logic [3:0] fs);
        return (fs == 4'd0) ? 4'd1 : fs;
    endfunction

    // Counters stop at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The timeout counter plus one, one bit wider so the limit 65535 is still reachable.
    assign tmo_inc = {1'b0, tmo_q} + 17'd1;

    // Judge the frame from the flags latched at rx_frame_done. The priority is noise, crc, framing, length.
    always_comb begin
        len_bad   = (wptr_q == 4'd0) || (wptr_q != len_q) || ovf_q;
        judge_err = ERR_NONE;
        if (nf_q) begin
            judge_err = ERR_NOISE;
        end else if (crce_q) begin
            judge_err = ERR_CRC;
        end else if (fe_q) begin
            judge_err = ERR_FRAMING;
        end else if (len_bad) begin
            judge_err = ERR_LENGTH;
        end
    end

    // Mark the byte being presented as the final one of the frame.
    assign last_rd = (rptr_q == (wptr_q - 4'd1));

    // Main sequencing: state transitions, pointers, flag capture and counters.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        len_d      = len_q;
        tmo_d      = tmo_q;
        ovf_d      = ovf_q;
        nf_d       = nf_q;
        crce_d     = crce_q;
        fe_d       = fe_q;
        pend_err_d = pend_err_q;
        err_code_d = err_code_q;
        good_d     = good_q;
        errc_d     = errc_q;
        baud_d     = baud_q;
        buf_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    baud_d  = cfg_baudrate;
                    state_d = ST_HUNT;
                end
            end

            ST_HUNT: begin
                if (!enable) begin
                    // Abort: the counters do not change.
                    wptr_d  = 4'd0;
                    rptr_d  = 4'd0;
                    ovf_d   = 1'b0;
                    tmo_d   = 16'd0;
                    state_d = ST_IDLE;
                end else begin
                    if (rx_byte_valid) begin
                        // The first byte always fits, because the pointer is 0 and the length is at least 1.
                        buf_we  = 1'b1;
                        wptr_d  = 4'd1;
                        len_d   = frame_len(rx_framesize);
                        tmo_d   = 16'd0;
                        state_d = ST_RECV;
                    end
                    if (rx_frame_done) begin
                        nf_d    = rx_nf;
                        crce_d  = rx_crce;
                        fe_d    = rx_fe;
                        state_d = ST_CHECK;
                    end
                end
            end

            ST_RECV: begin
                if (!enable) begin
                    wptr_d  = 4'd0;
                    rptr_d  = 4'd0;
                    ovf_d   = 1'b0;
                    tmo_d   = 16'd0;
                    state_d = ST_IDLE;
                end else begin
                    if (rx_byte_valid) begin
                        tmo_d = 16'd0;
                        if (wptr_q == len_q) begin
                            // A byte past the expected length is dropped, and the frame is marked as overlong.
                            ovf_d = 1'b1;
                        end else begin
                            buf_we = 1'b1;
                            wptr_d = wptr_q + 4'd1;
                        end
                    end else if (!rx_frame_done) begin
                        if (tmo_inc == TIMEOUT_LIMIT) begin
                            pend_err_d = ERR_TIMEOUT;
                            tmo_d      = 16'd0;
                            state_d    = ST_DROP;
                        end else begin
                            tmo_d = tmo_inc[15:0];
                        end
                    end
                    if (rx_frame_done) begin
                        nf_d    = rx_nf;
                        crce_d  = rx_crce;
                        fe_d    = rx_fe;
                        tmo_d   = 16'd0;
                        state_d = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                tmo_d = 16'd0;
                if (judge_err != ERR_NONE) begin
                    pend_err_d = judge_err;
                    state_d    = ST_DROP;
                end else begin
                    good_d     = sat_inc(good_q);
                    err_code_d = ERR_NONE;
                    rptr_d     = 4'd0;
                    state_d    = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (out_ready) begin
                    if (last_rd) begin
                        wptr_d  = 4'd0;
                        rptr_d  = 4'd0;
                        ovf_d   = 1'b0;
                        state_d = enable ? ST_HUNT : ST_IDLE;
                    end else begin
                        rptr_d = rptr_q + 4'd1;
                    end
                end
            end

            ST_DROP: begin
                err_code_d = pend_err_q;
                errc_d     = sat_inc(errc_q);
                wptr_d     = 4'd0;
                rptr_d     = 4'd0;
                ovf_d      = 1'b0;
                tmo_d      = 16'd0;
                state_d    = enable ? ST_HUNT : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register the control state. Reset asynchronously clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wptr_q     <= 4'd0;
            rptr_q     <= 4'd0;
            len_q      <= 4'd0;
            tmo_q      <= 16'd0;
            ovf_q      <= 1'b0;
            nf_q       <= 1'b0;
            crce_q     <= 1'b0;
            fe_q       <= 1'b0;
            pend_err_q <= ERR_NONE;
            err_code_q <= ERR_NONE;
            good_q     <= 8'd0;
            errc_q     <= 8'd0;
            baud_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            len_q      <= len_d;
            tmo_q      <= tmo_d;
            ovf_q      <= ovf_d;
            nf_q       <= nf_d;
            crce_q     <= crce_d;
            fe_q       <= fe_d;
            pend_err_q <= pend_err_d;
            err_code_q <= err_code_d;
            good_q     <= good_d;
            errc_q     <= errc_d;
            baud_q     <= baud_d;
        end
    end

    // Staging buffer. It is written only at the write pointer, and only while the frame has room.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= 8'd0;
            end
        end else if (buf_we) begin
            buf_q[wptr_q] <= rx_byte;
        end
    end

    // Outputs are decoded from state. Data is gated to 0 when no byte is offered.
    always_comb begin
        rx_arm      = (state_q == ST_HUNT) || (state_q == ST_RECV);
        busy        = (state_q != ST_IDLE);
        out_valid   = (state_q == ST_DRAIN);
        out_data    = out_valid ? buf_q[rptr_q] : 8'd0;
        out_last    = out_valid && last_rd;
        rx_baudrate = baud_q;
        err_code    = err_code_q;
        good_count  = good_q;
        err_count   = errc_q;
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: directed corner frames plus randomized frames.
// Expected results come from a frame-level model of the judging rules.
module tb_rx_frame_ctrl;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] cfg_baudrate;
  logic [7:0] rx_baudrate;
  logic       rx_arm;
  logic       rx_byte_valid;
  logic [7:0] rx_byte;
  logic [3:0] rx_framesize;
  logic       rx_frame_done;
  logic       rx_nf, rx_crce, rx_fe;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic [2:0] err_code;
  logic [7:0] good_count;
  logic [7:0] err_count;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // frame-level model state
  int good_exp = 0;
  int err_exp  = 0;
  int code_exp = 0;
  logic [7:0] exp_q[$];

  rx_frame_ctrl #(.TIMEOUT_CYCLES(TMO), .BUF_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_baudrate(cfg_baudrate), .rx_baudrate(rx_baudrate), .rx_arm(rx_arm),
    .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte), .rx_framesize(rx_framesize),
    .rx_frame_done(rx_frame_done), .rx_nf(rx_nf), .rx_crce(rx_crce), .rx_fe(rx_fe),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .err_code(err_code), .good_count(good_count), .err_count(err_count),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Drive one frame and compare the outcome with the model.
  // ready_mode: 0 always ready, 1 pattern 1,0,0,1,0,0..., 2 random
  task automatic run_frame(input logic [3:0] fs, input int nbytes, input logic nf,
                           input logic crce, input logic fe, input bit merge_done,
                           input bit fixed_data, input int ready_mode);
    logic [7:0] data[$];
    int L;
    int e;
    int cyc;
    logic [7:0] d;
    L = (fs == 4'd0) ? 1 : int'(fs);
    for (int i = 0; i < nbytes; i++) begin
      d = fixed_data ? (8'hA1 + 8'h11 * 8'(i)) : 8'($urandom_range(0, 255));
      data.push_back(d);
    end
    // byte phase
    for (int i = 0; i < nbytes; i++) begin
      rx_byte_valid = 1'b1;
      rx_byte       = data[i];
      rx_framesize  = (i == 0) ? fs : 4'($urandom_range(0, 15));
      if (i == nbytes - 1 && merge_done) begin
        rx_frame_done = 1'b1;
        rx_nf = nf; rx_crce = crce; rx_fe = fe;
      end
      tick();
      rx_byte_valid = 1'b0;
      rx_frame_done = 1'b0;
      rx_nf = 1'b0; rx_crce = 1'b0; rx_fe = 1'b0;
      if (!(i == nbytes - 1 && merge_done)) begin
        repeat ($urandom_range(0, 4)) tick();
      end
    end
    if (!merge_done || nbytes == 0) begin
      rx_frame_done = 1'b1;
      rx_nf = nf; rx_crce = crce; rx_fe = fe;
      tick();
      rx_frame_done = 1'b0;
      rx_nf = 1'b0; rx_crce = 1'b0; rx_fe = 1'b0;
    end
    // one cycle of judging: receiver disarmed, nothing offered
    check("judge_arm", rx_arm, 1'b0);
    check("judge_valid", out_valid, 1'b0);

    if (nf) e = 1;
    else if (crce) e = 2;
    else if (fe) e = 3;
    else if (nbytes != L) e = 4;
    else e = 0;

    if (e == 0) begin
      good_exp = sat(good_exp);
      code_exp = 0;
      exp_q = data;
      tick();
      check("valid_latency", out_valid, 1'b1);
      check("good_count", good_count, good_exp);
      check("err_code_ok", err_code, code_exp);
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 100) begin
        case (ready_mode)
          0: out_ready = 1'b1;
          1: out_ready = (cyc % 3 == 0);
          default: out_ready = ($urandom_range(0, 99) < 60);
        endcase
        check("drain_valid", out_valid, 1'b1);
        check("drain_data", out_data, exp_q[0]);
        check("drain_last", out_last, exp_q.size() == 1);
        check("drain_arm", rx_arm, 1'b0);
        tick();
        if (out_ready) void'(exp_q.pop_front());
        cyc++;
      end
      check("drain_bound", exp_q.size(), 0);
      out_ready = 1'b0;
      check("post_drain_valid", out_valid, 1'b0);
      check("post_drain_arm", rx_arm, 1'b1);
    end else begin
      err_exp  = sat(err_exp);
      code_exp = e;
      tick();
      check("drop_arm", rx_arm, 1'b0);
      check("drop_valid", out_valid, 1'b0);
      tick();
      check("rearm", rx_arm, 1'b1);
      check("err_code", err_code, code_exp);
      check("err_count", err_count, err_exp);
      check("good_unchanged", good_count, good_exp);
    end
  endtask

  initial begin
    int k;
    logic [3:0] fs;
    int L, nb, r;
    // clock/reset
    reset = 1'b1; enable = 1'b0; cfg_baudrate = 8'h00;
    rx_byte_valid = 1'b0; rx_byte = 8'h00; rx_framesize = 4'd0; rx_frame_done = 1'b0;
    rx_nf = 1'b0; rx_crce = 1'b0; rx_fe = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_arm", rx_arm, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_baud", rx_baudrate, 0);
    check("rst_counts", {err_code, good_count, err_count}, 0);
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // arm with baud 0x10
    cfg_baudrate = 8'h10; enable = 1'b1;
    tick();
    check("baud_latch", rx_baudrate, 8'h10);
    check("hunt_arm", rx_arm, 1);
    check("hunt_busy", busy, 1);

    // directed frames
    run_frame(4'd3, 3, 0, 0, 0, 0, 1, 0);   // A1,B2,C3 good
    run_frame(4'd2, 2, 0, 1, 1, 0, 0, 0);   // crc beats framing
    run_frame(4'd4, 3, 0, 0, 0, 0, 0, 0);   // short
    run_frame(4'd4, 5, 0, 0, 0, 0, 0, 0);   // long
    run_frame(4'd15, 16, 0, 0, 0, 0, 0, 0); // long at full depth
    run_frame(4'd15, 15, 0, 0, 0, 0, 0, 2); // full-size good frame after overflow
    run_frame(4'd5, 5, 0, 0, 0, 0, 0, 1);   // ready pattern 1,0,0
    run_frame(4'd2, 2, 0, 0, 0, 1, 0, 0);   // byte and done together
    run_frame(4'd3, 0, 0, 0, 0, 0, 0, 0);   // done while hunting
    run_frame(4'd0, 1, 0, 0, 0, 0, 0, 0);   // zero field means one byte
    run_frame(4'd3, 3, 1, 1, 1, 1, 0, 0);   // noise has priority

    // timeout: one byte, then silence
    rx_byte_valid = 1'b1; rx_byte = 8'h55; rx_framesize = 4'd5;
    tick();
    rx_byte_valid = 1'b0;
    for (k = 1; k <= 20; k++) begin
      tick();
      if (!rx_arm) break;
    end
    check("timeout_cycles", k, TMO);
    err_exp = sat(err_exp); code_exp = 5;
    tick();
    check("timeout_code", err_code, code_exp);
    check("timeout_count", err_count, err_exp);
    check("timeout_rearm", rx_arm, 1);

    // abort by enable=0 mid-frame
    rx_byte_valid = 1'b1; rx_framesize = 4'd4;
    tick();
    tick();
    rx_byte_valid = 1'b0; enable = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_counts", {good_count, err_count}, {8'(good_exp), 8'(err_exp)});
    enable = 1'b1;
    tick();
    check("abort_rearm", rx_arm, 1);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      fs = 4'($urandom_range(0, 15));
      L = (fs == 4'd0) ? 1 : int'(fs);
      r = $urandom_range(0, 9);
      if (r == 6) nb = L + 1;
      else if (r == 7) nb = L - 1;
      else if (r == 8) nb = 0;
      else nb = L;
      run_frame(fs, nb, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 0, 2);
    end

    // baud change mid-frame, then reset mid-frame
    rx_byte_valid = 1'b1; rx_framesize = 4'd6;
    tick();
    rx_byte_valid = 1'b0; cfg_baudrate = 8'h20;
    tick();
    check("baud_hold", rx_baudrate, 8'h10);
    #2 reset = 1'b1;
    #1;
    check("async_rst_arm", rx_arm, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_outs", {out_valid, out_data, out_last, err_code}, 0);
    check("async_rst_regs", {rx_baudrate, good_count, err_count}, 0);
    #3 reset = 1'b0;
    good_exp = 0; err_exp = 0; code_exp = 0;
    tick();
    check("rebaud", rx_baudrate, 8'h20);

    // saturation
    for (int i = 0; i < 260; i++) begin
      rx_byte_valid = 1'b1; rx_frame_done = 1'b1; rx_framesize = 4'd1; out_ready = 1'b1;
      tick();
      rx_byte_valid = 1'b0; rx_frame_done = 1'b0;
      tick();
      tick();
      good_exp = sat(good_exp);
    end
    out_ready = 1'b0;
    check("good_sat", good_count, good_exp);
    for (int i = 0; i < 260; i++) begin
      rx_frame_done = 1'b1;
      tick();
      rx_frame_done = 1'b0;
      tick();
      tick();
      err_exp = sat(err_exp);
    end
    check("err_sat", err_count, err_exp);
    check("err_sat_code", err_code, 4);
    check("sat_good_hold", good_count, good_exp);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Controller that sequences the serial frame receiver: arms it, times it, collects its bytes, and judges the completed frame.
- Judging uses the receiver's noise, CRC and framing flags, plus length and timeout checks.
- Good frames are committed into a 16-byte staging buffer and drained to the host over a valid/ready byte stream.
- Bad frames are discarded and counted. The block sits between the receiver and host logic.

Parameters:
TIMEOUT_CYCLES, 4096, max clk cycles allowed between received bytes in RECV before abort (1..65535)
BUF_DEPTH, 16, staging buffer bytes; fixed by the 4-bit frame size field

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  controller runs when high
cfg_baudrate  in  8  host baud setting
rx_baudrate  out  8  baud value driven to receiver; latched from cfg_baudrate on IDLE->HUNT only
rx_arm  out  1  high = receiver may hunt/receive; low forces receiver idle
rx_byte_valid  in  1  one-cycle strobe, rx_byte valid
rx_byte  in  8  received data byte
rx_framesize  in  4  frame length field, valid from first rx_byte_valid
rx_frame_done  in  1  one-cycle strobe after stop bit; flags valid this cycle
rx_nf, rx_crce, rx_fe  in  1 each  noise, CRC, framing error flags
out_valid  out  1  committed byte available
out_data  out  8  committed byte
out_last  out  1  high with final byte of frame
out_ready  in  1  host accepts byte when out_valid & out_ready
busy  out  1  high in any state but IDLE
err_code  out  3  last error: 0 none, 1 noise, 2 crc, 3 framing, 4 length, 5 timeout
good_count  out  8  committed frames, saturates at 255
err_count  out  8  dropped frames, saturates at 255

Behaviour:
- Reset values: all outputs 0, state IDLE, buffer write pointer 0, read pointer 0, timeout counter 0.
- Expected length L = rx_framesize, with 0 treated as 1. L is latched on the first byte of the frame.
- States and transitions:
  - IDLE: rx_arm=0. Goes to HUNT when enable=1, latching rx_baudrate that cycle.
  - HUNT: rx_arm=1, no timeout. The first rx_byte_valid stores the byte at wptr 0, latches L, and moves to RECV.
  - RECV: rx_arm=1. Each rx_byte_valid stores at wptr, increments wptr, and clears the timeout counter. Otherwise the counter increments; reaching TIMEOUT_CYCLES goes to DROP with err=5. rx_frame_done goes to CHECK.
  - CHECK: one cycle, rx_arm=0. Errors are judged with priority noise > crc > framing > length.
    - Length error: stored byte count != L, or a byte arrived while wptr == L (that byte is not stored; a flag is set).
    - Any error goes to DROP. No error: good_count++, err_code=0, then DRAIN.
  - DRAIN: rx_arm=0, out_valid=1, out_data=buf[rptr], out_last=(rptr==wptr-1). rptr advances on a handshake. The handshake on the last byte goes to HUNT (or IDLE if enable=0), clearing both pointers.
  - DROP: one cycle, rx_arm=0. err_count++, err_code set, pointers cleared. Then HUNT (or IDLE if enable=0).
- rx_frame_done in HUNT (no bytes seen) goes to CHECK with count 0, which is a length error.
- Simultaneous rx_byte_valid and rx_frame_done in HUNT/RECV: the byte is stored first, and CHECK includes it.
- Latency: rx_frame_done at cycle N -> CHECK at N+1 -> out_valid high at N+2.
- out_valid never drops without a handshake. out_data is stable while out_valid=1 and out_ready=0.
- Errors for flags raised in CHECK are latched from the rx_frame_done cycle. rx_* strobes in CHECK/DRAIN/DROP/IDLE are ignored.
- enable=0 in HUNT or RECV aborts to IDLE next cycle: no counter change, pointers cleared. In DRAIN the drain completes first.
- cfg_baudrate changes outside IDLE->HUNT do not affect rx_baudrate.
- Counters saturate; they do not wrap.
- reset mid-frame or mid-drain returns to IDLE immediately (async), and out_valid drops.

Test Plan:
- framesize=3, bytes A1,B2,C3, done with flags 0, out_ready=1 -> out_valid at done+2, outputs A1,B2,C3 with out_last on C3; good_count=1, err_code=0.
- framesize=2, two bytes, done with rx_crce=1 and rx_fe=1 -> no out_valid, err_count=1, err_code=2, back to HUNT with rx_arm=1 after one low cycle.
- framesize=4, only 3 bytes then done -> err_code=4. Separately, a 5th byte before done -> err_code=4, buffer shows no overflow.
- TIMEOUT_CYCLES=8, one byte then silence -> DROP exactly 8 cycles after the byte, err_code=5, err_count increments.
- Drain with out_ready toggling 1,0,0,1,... -> each byte presented stable until accepted, no loss or duplication; rx_arm=0 throughout the drain.
- cfg_baudrate changed 0x10->0x20 mid-RECV -> rx_baudrate stays 0x10. Reset asserted mid-RECV -> all outputs 0, state IDLE immediately.
